// File: rtl/fp32_pkg.sv
// Shared fp32 constants, field widths and the arithmetic-unit state encoding.
// Used by the multiplier and the bias adder.
package fp32_pkg;

  localparam int EXP_W    = 8;
  localparam int MAN_W    = 23;
  localparam int EXP_BIAS = 127;

  localparam logic [31:0] FP_QNAN    = 32'h7FC00000;
  localparam logic [31:0] FP_POS_INF = 32'h7F800000;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    NORM,
    ROUND,
    DONE
  } fp_state_t;

endpackage

// File: rtl/fp32_round_pack.sv
// Combinational round-to-nearest-even, overflow/underflow saturation and fp32 pack
// from a normalised {sign, exp, 1.mantissa, guard, sticky} tuple.
module fp32_round_pack
  import fp32_pkg::*;
(
  input  logic                    sign,
  input  logic signed [EXP_W+1:0] exp_in,
  input  logic [MAN_W:0]          man_in,
  input  logic                    guard,
  input  logic                    sticky,
  output logic [31:0]             result
);

  logic                    round_up;
  logic [MAN_W+1:0]        man_sum;
  logic signed [EXP_W+1:0] exp_adj;
  logic [MAN_W-1:0]        frac;

  always_comb begin
    round_up = guard & (sticky | man_in[0]);
    man_sum  = {1'b0, man_in} + {{(MAN_W+1){1'b0}}, round_up};
    // Carry out of the mantissa means 10.000..0; renormalise by one place.
    exp_adj  = exp_in + $signed({{(EXP_W+1){1'b0}}, man_sum[MAN_W+1]});
    frac     = man_sum[MAN_W+1] ? man_sum[MAN_W:1] : man_sum[MAN_W-1:0];

    if (exp_adj >= 10'sd255) begin
      result = {sign, FP_POS_INF[30:0]};
    end else if (exp_adj <= 10'sd0) begin
      result = {sign, 31'b0};
    end else begin
      result = {sign, exp_adj[EXP_W-1:0], frac};
    end
  end

endmodule

// File: rtl/fp_multiplier.sv
// Multi-cycle fp32 multiplier: capture, multiply, normalise, round.
// One result per five cycles; value_out holds until the next round completes.
module fp_multiplier
  import fp32_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] value_out
);

  fp_state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] a_reg, b_reg;

  // MUL-stage unpack and special-case resolution
  logic                    sa, sb, sign_c;
  logic [EXP_W-1:0]        ea, eb;
  logic [MAN_W-1:0]        fa, fb;
  logic                    a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [MAN_W:0]          ma, mb;
  logic [47:0]             prod_c;
  logic signed [EXP_W+1:0] exp_c;
  logic                    special_c;
  logic [31:0]             special_val_c;

  logic [47:0]             prod_r;
  logic                    sign_r;
  logic signed [EXP_W+1:0] exp_r;
  logic                    special_r;
  logic [31:0]             special_val_r;

  // NORM-stage results
  logic [MAN_W:0]          man_c, man_r;
  logic                    guard_c, guard_r, sticky_c, sticky_r;
  logic signed [EXP_W+1:0] exp_n_c, exp_n_r;

  logic [31:0]             rounded_c;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = MUL;
      MUL:     state_nxt = NORM;
      NORM:    state_nxt = ROUND;
      ROUND:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sa     = a_reg[31];
    sb     = b_reg[31];
    ea     = a_reg[30:23];
    eb     = b_reg[30:23];
    fa     = a_reg[22:0];
    fb     = b_reg[22:0];
    sign_c = sa ^ sb;

    // Exponent 0 covers both true zero and denormals, which are flushed.
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (ea == '1) && (fa == '0);
    b_inf  = (eb == '1) && (fb == '0);
    a_nan  = (ea == '1) && (fa != '0);
    b_nan  = (eb == '1) && (fb != '0);

    ma     = a_zero ? '0 : {1'b1, fa};
    mb     = b_zero ? '0 : {1'b1, fb};
    prod_c = {24'b0, ma} * {24'b0, mb};
    exp_c  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'(EXP_BIAS);

    special_c     = 1'b0;
    special_val_c = '0;
    if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero)) begin
      special_c     = 1'b1;
      special_val_c = FP_QNAN;
    end else if (a_inf || b_inf) begin
      special_c     = 1'b1;
      special_val_c = {sign_c, FP_POS_INF[30:0]};
    end else if (a_zero || b_zero) begin
      special_c     = 1'b1;
      special_val_c = {sign_c, 31'b0};
    end
  end

  // Product of two 1.x mantissas lies in [1,4): leading one is bit 47 or bit 46.
  always_comb begin
    if (prod_r[47]) begin
      man_c    = prod_r[47:24];
      guard_c  = prod_r[23];
      sticky_c = |prod_r[22:0];
      exp_n_c  = exp_r + 10'sd1;
    end else begin
      man_c    = prod_r[46:23];
      guard_c  = prod_r[22];
      sticky_c = |prod_r[21:0];
      exp_n_c  = exp_r;
    end
  end

  fp32_round_pack u_round_pack (
    .sign   (sign_r),
    .exp_in (exp_n_r),
    .man_in (man_r),
    .guard  (guard_r),
    .sticky (sticky_r),
    .result (rounded_c)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_reg         <= '0;
      b_reg         <= '0;
      prod_r        <= '0;
      sign_r        <= 1'b0;
      exp_r         <= '0;
      special_r     <= 1'b0;
      special_val_r <= '0;
      man_r         <= '0;
      guard_r       <= 1'b0;
      sticky_r      <= 1'b0;
      exp_n_r       <= '0;
      value_out     <= '0;
      done          <= 1'b0;
    end else begin
      done <= (state == ROUND);
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= a_in;
            b_reg <= b_in;
          end
        end
        MUL: begin
          prod_r        <= prod_c;
          sign_r        <= sign_c;
          exp_r         <= exp_c;
          special_r     <= special_c;
          special_val_r <= special_val_c;
        end
        NORM: begin
          man_r    <= man_c;
          guard_r  <= guard_c;
          sticky_r <= sticky_c;
          exp_n_r  <= exp_n_c;
        end
        ROUND: begin
          value_out <= special_r ? special_val_r : rounded_c;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_multiplier.sv
// Self-checking bench for fp_multiplier: directed vectors, start-hold, mid-op reset
// and randomised operands against an integer-arithmetic fp32 reference.
module tb_fp_multiplier;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [31:0] a_in, b_in;
  logic        done;
  logic [31:0] value_out;

  int checks = 0;
  int errors = 0;

  fp_multiplier #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .a_in      (a_in),
    .b_in      (b_in),
    .done      (done),
    .value_out (value_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, expv);
    end
  endtask

  // Exact product of the 24-bit significands, then RNE by remainder comparison.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic              s;
    int                ea, eb, e, sh;
    longint unsigned   fa, fb, ma, mb, p, q, rem, half;
    bit                az, bz, ai, bi, an, bn;
    logic [31:0]       r;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    fa = longint'(a[22:0]);
    fb = longint'(b[22:0]);
    az = (ea == 0);
    bz = (eb == 0);
    ai = (ea == 255) && (fa == 0);
    bi = (eb == 255) && (fb == 0);
    an = (ea == 255) && (fa != 0);
    bn = (eb == 255) && (fb != 0);
    if (an || bn || (az && bi) || (ai && bz)) return 32'h7FC00000;
    if (ai || bi) return {s, 31'h7F800000};
    if (az || bz) return {s, 31'h0};
    ma = (64'd1 << 23) + fa;
    mb = (64'd1 << 23) + fb;
    p  = ma * mb;
    e  = ea + eb - 127;
    if (p >= (64'd1 << 47)) begin
      sh = 24;
      e  = e + 1;
    end else begin
      sh = 23;
    end
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return {s, 31'h7F800000};
    if (e <= 0) return {s, 31'h0};
    r = {s, e[7:0], q[22:0]};
    return r;
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] sp [6] = '{32'h00000000, 32'h80000000, 32'h7F800000,
                            32'hFF800000, 32'h7FC00001, 32'h00012345};
    logic [31:0] w;
    int unsigned kind;
    kind = $urandom_range(0, 9);
    w = $urandom;
    case (kind)
      0:       w = sp[$urandom_range(0, 5)];
      1, 2:    ;
      3:       w[30:23] = 8'($urandom_range(190, 254));
      4:       w[30:23] = 8'($urandom_range(1, 70));
      default: w[30:23] = 8'($urandom_range(100, 154));
    endcase
    return w;
  endfunction

  // Called away from a clock edge with the DUT idle; returns at the negedge after done falls.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] expv, input string tag);
    int n;
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a_in  = $urandom;
    b_in  = $urandom;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!done && n < 20);
    check({tag, "_lat"}, 32'(n), 32'd3);
    check({tag, "_val"}, value_out, expv);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_pulse"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    int first_done;
    int gap;
    logic [31:0] ra, rb;

    rstn  = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    #22;
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_val", value_out, 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    run_op(32'h40000000, 32'h40400000, 32'h40C00000, "two_x_three");
    run_op(32'hBFC00000, 32'h40800000, 32'hC0C00000, "neg");
    run_op(32'h3F800001, 32'h3F800001, 32'h3F800002, "rne_lsb");
    run_op(32'h3F800001, 32'h3FC00000, 32'h3FC00002, "tie_up");
    run_op(32'h3F800003, 32'h3FC00000, 32'h3FC00004, "tie_even");
    run_op(32'h00000000, 32'h7F800000, 32'h7FC00000, "zero_inf");
    run_op(32'h7F000000, 32'h7F000000, 32'h7F800000, "overflow");
    run_op(32'h00800000, 32'h00800000, 32'h00000000, "underflow");
    run_op(32'h80000000, 32'h40400000, 32'h80000000, "neg_zero");
    run_op(32'hFF800000, 32'h40000000, 32'hFF800000, "neg_inf");
    run_op(32'h00012345, 32'h40000000, 32'h00000000, "denorm");

    // start held high for ten edges; operands disturbed only while in MUL
    ndone      = 0;
    first_done = -1;
    gap        = -1;
    a_in  = 32'h40000000;
    b_in  = 32'h40400000;
    start = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk);
      #1;
      if (i == 10) start = 1'b0;
      if (i == 1 || i == 6) begin
        a_in = $urandom;
        b_in = $urandom;
      end
      if (i == 2 || i == 7) begin
        a_in = 32'h40000000;
        b_in = 32'h40400000;
      end
      @(negedge clk);
      if (done) begin
        ndone++;
        check("hold_val", value_out, 32'h40C00000);
        if (first_done < 0) first_done = i;
        else gap = i - first_done;
      end
    end
    check("hold_count", 32'(ndone), 32'd2);
    check("hold_gap", 32'(gap), 32'd5);

    // reset asserted while the operation is in NORM
    a_in  = 32'h40000000;
    b_in  = 32'h40400000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("midrst_val", value_out, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_hold", {31'b0, done}, 32'd0);
    end
    rstn = 1'b1;
    run_op(32'h40A00000, 32'h40000000, 32'h41200000, "after_rst");

    for (int i = 0; i < 60; i++) begin
      ra = rand_fp();
      rb = rand_fp();
      run_op(ra, rb, ref_mul(ra, rb), $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
